fw_coef_loader: RTL and testbench

- Write-side counterpart of the fixed 3-bit coefficient ROMs used by the BWN datapath.
- Accepts a valid/ready stream of packed 12-bit beats, each holding four 3-bit coefficients, and unpacks them into a register-based coefficient store.
- The store exposes the same combinational addr -> coef read port as the ROMs, so the datapath can swap a ROM for this block unchanged.
- Sits between the host/DMA weight stream and the compute array's coefficient fetch.

---
 rtl/fw_coef_pkg.sv | 15 +
 rtl/fw_coef_unpack.sv | 36 +++
 rtl/fw_coef_loader.sv | 160 ++++++++++++++++
 tb/tb_fw_coef_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_coef_pkg.sv
// Shared constants and FSM encoding for the coefficient loader.
// Used by fw_coef_loader (optional parity port under FW_COEF_PARITY_EN) and fw_coef_unpack.
package fw_coef_pkg;

  localparam int unsigned COEF_W = 3;
  localparam int unsigned LANES  = 4;
  localparam int unsigned DIN_W  = COEF_W * LANES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/fw_coef_unpack.sv
// Splits a packed beat into per-lane write enables, addresses and data,
// clipping lanes that fall at or beyond NUM_COEF.
module fw_coef_unpack
  import fw_coef_pkg::*;
#(
  parameter int unsigned WIDTH_A  = 12,
  parameter int unsigned NUM_COEF = 40
) (
  input  logic [DIN_W-1:0]                i_data,
  input  logic [WIDTH_A-1:0]              i_load_cnt,
  output logic [LANES-1:0]                o_we,
  output logic [LANES-1:0][WIDTH_A-1:0]   o_addr,
  output logic [LANES-1:0][COEF_W-1:0]    o_data,
  output logic [WIDTH_A-1:0]              o_next_cnt,
  output logic                            o_last
);

  localparam logic [WIDTH_A:0] L_NUM = (WIDTH_A + 1)'(NUM_COEF);

  // One extra bit so load_cnt + k never wraps before the compare.
  logic [LANES-1:0][WIDTH_A:0] w_pos;
  logic [WIDTH_A:0]            w_end;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_pos[k]  = {1'b0, i_load_cnt} + (WIDTH_A + 1)'(k);
      o_we[k]   = (w_pos[k] < L_NUM);
      o_addr[k] = w_pos[k][WIDTH_A-1:0];
      o_data[k] = i_data[k*COEF_W +: COEF_W];
    end
    w_end      = {1'b0, i_load_cnt} + (WIDTH_A + 1)'(LANES);
    o_last     = (w_end >= L_NUM);
    o_next_cnt = o_last ? L_NUM[WIDTH_A-1:0] : w_end[WIDTH_A-1:0];
  end

endmodule

// File: rtl/fw_coef_loader.sv
// Streams packed 3-bit coefficients into a register store with a ROM-compatible read port.
// Define FW_COEF_PARITY_EN to add a running XOR of the coefficients written in the current load.
module fw_coef_loader
  import fw_coef_pkg::*;
#(
  parameter int unsigned WIDTH_A  = 12,
  parameter int unsigned NUM_COEF = 40,
  parameter int unsigned LANES    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [COEF_W*LANES-1:0]  in_data,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH_A-1:0]       load_cnt,
  input  logic [WIDTH_A-1:0]       addr,
  output logic [COEF_W-1:0]        coef
`ifdef FW_COEF_PARITY_EN
  ,
  output logic [COEF_W-1:0]        parity
`endif
);

  state_e               r_state;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH_A-1:0]   r_cnt;
  logic [COEF_W-1:0]    r_store [NUM_COEF];

  logic [LANES-1:0]                w_we;
  logic [LANES-1:0][WIDTH_A-1:0]   w_addr;
  logic [LANES-1:0][COEF_W-1:0]    w_data;
  logic [WIDTH_A-1:0]              w_next_cnt;
  logic                            w_last;
  logic                            w_accept;
  logic [COEF_W-1:0]               w_coef;

  fw_coef_unpack #(
    .WIDTH_A  (WIDTH_A),
    .NUM_COEF (NUM_COEF)
  ) u_unpack (
    .i_data     (in_data),
    .i_load_cnt (r_cnt),
    .o_we       (w_we),
    .o_addr     (w_addr),
    .o_data     (w_data),
    .o_next_cnt (w_next_cnt),
    .o_last     (w_last)
  );

  // start wins over a handshake in the same cycle.
  assign w_accept = (r_state == ST_LOAD) && r_ready && in_valid && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (start) begin
            r_cnt <= '0;
          end else if (w_accept) begin
            r_cnt <= w_next_cnt;
            if (w_last) begin
              r_state <= ST_DONE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        r_store[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        for (int k = 0; k < LANES; k++) begin
          if (w_we[k] && (w_addr[k] == WIDTH_A'(i))) begin
            r_store[i] <= w_data[k];
          end
        end
      end
    end
  end

  // Out-of-range addresses fall through to zero.
  always_comb begin
    w_coef = '0;
    for (int i = 0; i < NUM_COEF; i++) begin
      if (addr == WIDTH_A'(i)) begin
        w_coef = r_store[i];
      end
    end
  end

  assign in_ready = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign load_cnt = r_cnt;
  assign coef     = w_coef;

`ifdef FW_COEF_PARITY_EN
  logic [COEF_W-1:0] r_parity;
  logic [COEF_W-1:0] w_beat_xor;

  always_comb begin
    w_beat_xor = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w_we[k]) begin
        w_beat_xor = w_beat_xor ^ w_data[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= '0;
    end else if (start) begin
      r_parity <= '0;
    end else if (w_accept) begin
      r_parity <= r_parity ^ w_beat_xor;
    end
  end

  assign parity = r_parity;
`else
  // Parity tracking compiled out.
`endif

endmodule

// File: tb/tb_fw_coef_loader.sv
// Randomized bench for fw_coef_loader: two instances (40 and 10 coefficients) against a
// behavioural model of the load rules.
module tb_fw_coef_loader;

  localparam int unsigned WA  = 12;
  localparam int          NC0 = 40;
  localparam int          NC1 = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             st [2];
  logic             in_valid;
  logic [11:0]      in_data;
  logic [WA-1:0]    addr;
  logic             rdy [2];
  logic             bsy [2];
  logic             dn  [2];
  logic [WA-1:0]    cnt [2];
  logic [2:0]       cf  [2];
`ifdef FW_COEF_PARITY_EN
  logic [2:0]       par [2];
`endif

  always #5 clk = ~clk;

  fw_coef_loader #(.WIDTH_A(WA), .NUM_COEF(NC0), .LANES(4)) u_dut40 (
    .clk      (clk),
    .rst      (rst),
    .start    (st[0]),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (rdy[0]),
    .busy     (bsy[0]),
    .done     (dn[0]),
    .load_cnt (cnt[0]),
    .addr     (addr),
    .coef     (cf[0])
`ifdef FW_COEF_PARITY_EN
    ,
    .parity   (par[0])
`endif
  );

  fw_coef_loader #(.WIDTH_A(WA), .NUM_COEF(NC1), .LANES(4)) u_dut10 (
    .clk      (clk),
    .rst      (rst),
    .start    (st[1]),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (rdy[1]),
    .busy     (bsy[1]),
    .done     (dn[1]),
    .load_cnt (cnt[1]),
    .addr     (addr),
    .coef     (cf[1])
`ifdef FW_COEF_PARITY_EN
    ,
    .parity   (par[1])
`endif
  );

  // Behavioural model state
  int m_n [2];
  int m_st [2][40];
  int m_cnt [2];
  bit m_load [2];
  bit m_done [2];
  int m_par [2];

  int n_checks;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 40; a++) m_st[i][a] = 0;
      m_cnt[i]  = 0;
      m_load[i] = 0;
      m_done[i] = 0;
      m_par[i]  = 0;
    end
  endtask

  // Applies the inputs currently present to the model, as the next clock edge will.
  task automatic model_edge(input int i);
    int lane;
    if (st[i]) begin
      m_load[i] = 1;
      m_done[i] = 0;
      m_cnt[i]  = 0;
      m_par[i]  = 0;
    end else if (m_load[i] && in_valid) begin
      for (int k = 0; k < 4; k++) begin
        if (m_cnt[i] + k < m_n[i]) begin
          lane = int'((in_data >> (3 * k)) & 12'h7);
          m_st[i][m_cnt[i] + k] = lane;
          m_par[i] = m_par[i] ^ lane;
        end
      end
      m_cnt[i] += (m_n[i] - m_cnt[i] < 4) ? (m_n[i] - m_cnt[i]) : 4;
      if (m_cnt[i] == m_n[i]) begin
        m_load[i] = 0;
        m_done[i] = 1;
      end
    end
  endtask

  function automatic int exp_coef(input int i, input int a);
    return (a < m_n[i]) ? m_st[i][a] : 0;
  endfunction

  task automatic check_outs();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(m_load[i]));
      chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(m_load[i]));
      chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(m_done[i]));
      chk($sformatf("load_cnt[%0d]", i), 32'(cnt[i]), 32'(m_cnt[i]));
      chk($sformatf("coef[%0d]@%0d", i, addr), 32'(cf[i]), 32'(exp_coef(i, int'(addr))));
`ifdef FW_COEF_PARITY_EN
      chk($sformatf("parity[%0d]", i), 32'(par[i]), 32'(m_par[i]));
`endif
    end
  endtask

  task automatic step();
    addr = WA'($urandom_range(0, 47));
    for (int i = 0; i < 2; i++) model_edge(i);
    @(posedge clk);
    #1;
    check_outs();
  endtask

  // Reads every address of both instances; assumes no input activity meanwhile.
  task automatic sweep();
    for (int a = 0; a < 48; a++) begin
      addr = WA'(a);
      #1;
      for (int i = 0; i < 2; i++)
        chk($sformatf("sweep_coef[%0d]@%0d", i, a), 32'(cf[i]), 32'(exp_coef(i, a)));
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  exp4 [4];
    bit  acc;
    int  x;
    exp4 = '{7, 2, 6, 4};
    m_n[0] = NC0;
    m_n[1] = NC1;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    st[0] = 1'b0;
    st[1] = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    addr     = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outs();
    sweep();
    rst = 1'b0;

    // Full 40-coefficient load, back-to-back
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    in_valid = 1'b1;
    for (int b = 0; b < 10; b++) begin
      in_data = (b == 0) ? {3'd4, 3'd6, 3'd2, 3'd7} : 12'($urandom);
      step();
    end
    chk("full_done", 32'(dn[0]), 32'd1);
    chk("full_cnt", 32'(cnt[0]), 32'd40);
    in_valid = 1'b0;
    step();
    chk("full_ready_low", 32'(rdy[0]), 32'd0);
    for (int a = 0; a < 4; a++) begin
      addr = WA'(a);
      #1;
      chk($sformatf("beat0_lane%0d", a), 32'(cf[0]), 32'(exp4[a]));
    end
    sweep();

    // Backpressure with partial last beat on the 10-entry instance
    st[1] = 1'b1;
    step();
    st[1] = 1'b0;
    in_data = 12'($urandom);
    for (int c = 0; c < 200 && !m_done[1]; c++) begin
      if (!in_valid) in_valid = 1'($urandom_range(0, 1));
      acc = in_valid && m_load[1];
      step();
      if (acc) begin
        in_data  = 12'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
    end
    chk("bp_completed", 32'(m_done[1]), 32'd1);
    chk("bp_cnt", 32'(cnt[1]), 32'd10);
    in_valid = 1'b0;
    step();
    addr = WA'(10);
    #1;
    chk("bp_addr10", 32'(cf[1]), 32'd0);
    sweep();

    // Restart mid-load: start with a simultaneous beat ignores the beat
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin
      in_data = 12'($urandom);
      step();
    end
    st[0] = 1'b1;
    in_data = 12'($urandom);
    step();
    st[0] = 1'b0;
    chk("restart_cnt", 32'(cnt[0]), 32'd0);
`ifdef FW_COEF_PARITY_EN
    chk("restart_parity", 32'(par[0]), 32'd0);
`endif
    repeat (10) begin
      in_data = 12'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("restart_done", 32'(dn[0]), 32'd1);
`ifdef FW_COEF_PARITY_EN
    x = 0;
    for (int a = 0; a < 40; a++) x = x ^ m_st[0][a];
    chk("parity_all40", 32'(par[0]), 32'(x));
`endif
    sweep();

    // Asynchronous reset in the middle of a load
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      in_data = 12'($urandom);
      step();
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_outs();
    chk("arst_busy", 32'(bsy[0]), 32'd0);
    chk("arst_cnt", 32'(cnt[0]), 32'd0);
    in_valid = 1'b0;
    sweep();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Load after reset on the 10-entry instance, back-to-back
    st[1] = 1'b1;
    step();
    st[1] = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      in_data = 12'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("post_rst_done10", 32'(dn[1]), 32'd1);
    sweep();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
